// File: rtl/uart_console_pkg.sv
// Shared types and constants for the console arbiter and its per-requester line buffers.
// Pure declarations: no latency, no backpressure.
package uart_console_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    COMMITTED = 2'd1,
    DRAINING  = 2'd2
  } buf_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  localparam logic [7:0] NEWLINE = 8'h0A;

endpackage

// File: rtl/uart_console_arbiter_buffer.sv
// Per-requester line buffer: fills until newline, full or idle timeout, then waits for a drain.
// Accepts one byte per cycle in FILL only; the requester stalls while the line is committed or draining.
module uart_line_buffer import uart_console_pkg::*; #(
  parameter int LINE_BYTES   = 64,
  parameter int FLUSH_CYCLES = 1024,
  localparam int AW = $clog2(LINE_BYTES),
  localparam int FW = (FLUSH_CYCLES == 0) ? 1 : $clog2(FLUSH_CYCLES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [7:0]    wr_ch,
  output logic          wr_ready,
  output logic          committed,
  input  logic          start_drain,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          drain_done,
  output logic [AW:0]   cnt
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(LINE_BYTES);

  buf_state_e    state;
  logic [7:0]    mem [LINE_BYTES];
  logic [FW-1:0] flush_cnt;
  logic          accept;
  logic          flush_hit;

  assign wr_ready   = (state == FILL);
  assign accept     = wr_valid & wr_ready;
  assign committed  = (state == COMMITTED);
  assign rd_data    = mem[rd_idx];
  assign drain_done = (state == DRAINING) && ({1'b0, rd_idx} == (cnt - ONE));
  // Commit on the edge where the idle counter reaches FLUSH_CYCLES.
  assign flush_hit  = (FLUSH_CYCLES != 0) && (cnt != '0) && !accept &&
                      (flush_cnt == FW'(FLUSH_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (accept) mem[cnt[AW-1:0]] <= wr_ch;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept || cnt == '0) flush_cnt <= '0;
      else if (flush_cnt != '1) flush_cnt <= flush_cnt + FW'(1);

      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + ONE;
            if (wr_ch == NEWLINE || (cnt + ONE) == FULL) state <= COMMITTED;
          end else if (flush_hit) begin
            state <= COMMITTED;
          end
        end
        COMMITTED: if (start_drain) state <= DRAINING;
        DRAINING: begin
          if (drain_done) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: rtl/uart_console_arbiter.sv
// Round-robin console arbiter: emits committed lines atomically, first byte 2 cycles after commit, one gap cycle between lines.
// Sink is never backpressured; requesters stall via req_ready while their own line is pending.
module uart_console_arbiter import uart_console_pkg::*; #(
  parameter int N_REQ        = 4,
  parameter int LINE_BYTES   = 64,
  parameter int FLUSH_CYCLES = 1024,
  localparam int GW = $clog2(N_REQ),
  localparam int AW = $clog2(LINE_BYTES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_ch,
  output logic [N_REQ-1:0]   req_ready,
  output logic               putchar_valid,
  output logic [7:0]         putchar_ch,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  arb_state_e       state;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    grant;
  logic [AW-1:0]    rd_idx;
  logic [N_REQ-1:0] committed;
  logic [N_REQ-1:0] start_drain;
  logic [N_REQ-1:0] drain_done;
  logic [7:0]       rd_data [N_REQ];
  logic [AW:0]      cnt     [N_REQ];
  logic [GW-1:0]    sel;
  logic             sel_vld;
  logic             any_cnt;
  int               idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_buf
    uart_line_buffer #(
      .LINE_BYTES   (LINE_BYTES),
      .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_buf (
      .clock       (clock),
      .reset       (reset),
      .wr_valid    (req_valid[g]),
      .wr_ch       (req_ch[8*g +: 8]),
      .wr_ready    (req_ready[g]),
      .committed   (committed[g]),
      .start_drain (start_drain[g]),
      .rd_idx      (rd_idx),
      .rd_data     (rd_data[g]),
      .drain_done  (drain_done[g]),
      .cnt         (cnt[g])
    );
  end

  // Walk from farthest to nearest so the first committed index at/after rr_ptr wins.
  always_comb begin
    sel     = rr_ptr;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (committed[idx]) begin
        sel     = GW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    start_drain = '0;
    if (state == IDLE && sel_vld) start_drain[sel] = 1'b1;
  end

  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < N_REQ; i++) any_cnt = any_cnt | (cnt[i] != '0);
  end

  assign busy = (state == DRAIN) | any_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      rd_idx        <= '0;
      putchar_valid <= 1'b0;
      putchar_ch    <= '0;
      grant_id      <= '0;
    end else begin
      putchar_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant  <= sel;
            rd_idx <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          putchar_valid <= 1'b1;
          putchar_ch    <= rd_data[grant];
          grant_id      <= grant;
          rd_idx        <= rd_idx + AW'(1);
          if (drain_done[grant]) begin
            state  <= IDLE;
            rr_ptr <= (grant == GW'(N_REQ - 1)) ? '0 : grant + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_console_arbiter.sv
// Scoreboard bench for uart_console_arbiter: stimulus pushes expected {grant,byte}, a negedge monitor pops and compares.
module tb_uart_console_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_ch;
  logic [3:0]  req_ready;
  logic        putchar_valid;
  logic [7:0]  putchar_ch;
  logic        busy;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb [$];
  logic       prev_vld = 1'b0;
  logic [1:0] prev_gid = '0;

  uart_console_arbiter #(
    .N_REQ        (4),
    .LINE_BYTES   (8),
    .FLUSH_CYCLES (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ch        (req_ch),
    .req_ready     (req_ready),
    .putchar_valid (putchar_valid),
    .putchar_ch    (putchar_ch),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic exp(input int gid, input logic [7:0] ch);
    logic [1:0] g;
    g = 2'(gid);
    sb.push_back({g, ch});
  endtask

  // Presents all masked lanes in one cycle, only once every one of them is ready.
  task automatic send_vec(input logic [3:0] mask, input logic [31:0] chs);
    int n;
    n = 0;
    @(negedge clock);
    while ((req_ready & mask) != mask && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready=%h, needed=%h", req_ready, mask);
    end else begin
      req_ch    = chs;
      req_valid = mask;
      @(posedge clock);
      #1 req_valid = '0;
    end
  endtask

  task automatic send(input int id, input logic [7:0] ch);
    logic [31:0] v;
    logic [3:0]  m;
    v = '0;
    m = '0;
    v[8*id +: 8] = ch;
    m[id] = 1'b1;
    send_vec(m, v);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d bytes still expected, expected 0", name, sb.size());
    end
    repeat (2) @(negedge clock);
    check({name, "_busy_after"}, 32'(busy), 32'd0);
    check({name, "_valid_after"}, 32'(putchar_valid), 32'd0);
  endtask

  always @(negedge clock) begin
    if (putchar_valid === 1'b1) begin
      if (prev_vld) check("no_mid_line_switch", 32'(grant_id), 32'(prev_gid));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL putchar_unexpected: got gid=%0d ch=%h, expected no output", grant_id, putchar_ch);
      end else begin
        check("putchar", {22'd0, grant_id, putchar_ch}, {22'd0, sb.pop_front()});
      end
      prev_vld = 1'b1;
      prev_gid = grant_id;
    end else begin
      prev_vld = 1'b0;
    end
  end

  initial begin
    int lat;
    logic [7:0] c;

    reset = 1'b0;
    req_valid = '0;
    req_ch = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_valid", 32'(putchar_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant_id), 32'd0);
    check("reset_ch", 32'(putchar_ch), 32'd0);
    reset = 1'b1;
    check("ready_after_reset", 32'(req_ready), 32'hF);

    // Round-robin: two rounds of simultaneous commits, both start from pointer 0.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        exp(i, 8'h78);
        exp(i, 8'h0A);
      end
      send_vec(4'hF, 32'h78787878);
      send_vec(4'hF, 32'h0A0A0A0A);
    end
    wait_empty("round_robin");

    // Single line "hi\n" on requester 0.
    exp(0, 8'h68); exp(0, 8'h69); exp(0, 8'h0A);
    send(0, 8'h68);
    send(0, 8'h69);
    send(0, 8'h0A);
    wait_empty("single_line");

    // Interleaved producers must still come out as whole lines.
    for (int i = 0; i < 5; i++) exp(0, (i == 4) ? 8'h0A : 8'h41);
    for (int i = 0; i < 5; i++) exp(1, (i == 4) ? 8'h0A : 8'h42);
    for (int i = 0; i < 5; i++) begin
      send(0, (i == 4) ? 8'h0A : 8'h41);
      send(1, (i == 4) ? 8'h0A : 8'h42);
    end
    wait_empty("interleave");

    // Full buffer: 8 bytes commit without newline, remaining 2 flush later.
    for (int i = 0; i < 10; i++) exp(2, 8'h31 + 8'(i));
    for (int i = 0; i < 8; i++) send(2, 8'h31 + 8'(i));
    @(negedge clock);
    check("full_stall_ready", 32'(req_ready[2]), 32'd0);
    check("full_others_ready", 32'(req_ready & 4'hB), 32'hB);
    send(2, 8'h39);
    send(2, 8'h3A);
    wait_empty("full_buffer");

    // Idle timeout: one byte, no newline.
    exp(1, 8'h41);
    send(1, 8'h41);
    lat = 0;
    while (putchar_valid !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("flush_latency", 32'(lat), 32'd11);
    wait_empty("timeout");

    // Reset during the second byte of "abcd\n" on requester 3.
    exp(3, 8'h61); exp(3, 8'h62);
    c = 8'h61;
    for (int i = 0; i < 5; i++) send(3, (i == 4) ? 8'h0A : c + 8'(i));
    lat = 0;
    while (!(putchar_valid === 1'b1 && putchar_ch == 8'h62) && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check("mid_drain_second_byte_seen", 32'(lat < 50), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_valid", 32'(putchar_valid), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("mid_reset_no_leftover", 32'(sb.size()), 32'd0);
    check("mid_reset_busy_after", 32'(busy), 32'd0);
    check("mid_reset_ready", 32'(req_ready), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_console_arbiter.md
Name: uart_console_arbiter

Overview:
- Shares the single simulation UART putchar channel (the DPI console sink) between N_REQ independent byte producers (harts, debug module, boot ROM stub).
- Each requester owns a line buffer; complete lines are emitted atomically so console text from different requesters never interleaves mid-line.
- Sits between the requesters and the UART helper's putchar_valid/putchar_ch inputs. The arbiter never drives getchar.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- LINE_BYTES, 64, per-requester line buffer depth in bytes (power of two, 4..256)
- FLUSH_CYCLES, 1024, idle cycles after which a partial line is force-committed; 0 disables the timeout

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low; asserted when 0, sampled on the rising edge of clock
- req_valid  in  N_REQ  requester i offers byte req_ch[i]
- req_ch  in  N_REQ*8  byte lanes, lane i = bits [8i+7:8i]
- req_ready  out  N_REQ  requester i byte accepted when req_valid[i] & req_ready[i]
- putchar_valid  out  1  byte presented to the UART sink this cycle
- putchar_ch  out  8  byte to the sink
- busy  out  1  any buffer non-empty or drain in progress
- grant_id  out  clog2(N_REQ)  requester being drained; valid when putchar_valid

Behaviour:
- Reset (reset==0 at a clock edge): all counts 0, every buffer in FILL state, arbiter in IDLE, round-robin pointer 0, flush counters 0. Outputs: putchar_valid=0, putchar_ch=0, busy=0, grant_id=0, req_ready=all 1 from the first cycle after reset release. Reset mid-drain discards all buffered data, and no further putchar_valid pulses are issued.
- Per-requester buffer states: FILL, COMMITTED, DRAINING.
  - FILL: req_ready[i]=1 and cnt<LINE_BYTES. An accepted byte is written at index cnt, then cnt++.
  - FILL -> COMMITTED when any of these holds:
    - the accepted byte is 0x0A; the newline is stored and emitted.
    - cnt reaches LINE_BYTES after the write.
    - FLUSH_CYCLES!=0, cnt>0 and the flush counter reaches FLUSH_CYCLES.
  - Flush counter: resets to 0 on every accepted byte and while cnt==0; otherwise increments each cycle, saturating.
  - COMMITTED and DRAINING: req_ready[i]=0, bytes are not accepted and not dropped (requester stalls).
- Arbiter states: IDLE, DRAIN.
  - IDLE: if any buffer is COMMITTED, grant the first COMMITTED index at or after rr_ptr (wrapping modulo N_REQ). The grant registers in that cycle; the buffer moves to DRAINING and the arbiter moves to DRAIN with rd_idx=0. Latency: commit edge -> first putchar_valid is at least 1 cycle after the COMMITTED state is visible.
  - DRAIN: putchar_valid=1 every cycle, putchar_ch=buf[grant][rd_idx], grant_id=grant, rd_idx++. No backpressure; the sink always accepts.
  - DRAIN, on the last byte (rd_idx==cnt-1): the next state is IDLE, that buffer returns to FILL with cnt=0, and rr_ptr=(grant+1) mod N_REQ. There is one idle cycle between consecutive lines.
- Simultaneous events:
  - Several commits in the same cycle are resolved by round-robin only.
  - A requester may write its own buffer the cycle after the drain completes.
  - Other requesters keep filling during any drain.
- putchar_ch holds its last value when putchar_valid=0. The value is don't-care to consumers, but the RTL must be deterministic.
- busy = (arbiter in DRAIN) | OR over i of (cnt[i]!=0).
- Widths: cnt is clog2(LINE_BYTES)+1 bits. The flush counter is clog2(FLUSH_CYCLES+1) bits.

Decomposition:
- Shared package uart_console_pkg:
  - buf_state_e {FILL, COMMITTED, DRAINING}
  - arb_state_e {IDLE, DRAIN}
  - constant NEWLINE = 8'h0A
- One sub-module: uart_line_buffer, instantiated N_REQ times. It contains the storage, cnt, flush counter and FILL/COMMITTED/DRAINING state, and exposes:
  - committed
  - start_drain
  - rd_idx
  - rd_data
  - drain_done
- The top level holds the round-robin pointer, the IDLE/DRAIN FSM and the output mux.

Test Plan:
- Single line: requester 0 sends "hi\n" (0x68,0x69,0x0A) -> exactly 3 consecutive putchar_valid cycles carrying 0x68,0x69,0x0A with grant_id=0; busy=0 afterwards.
- Interleave guard: req0 and req1 alternate bytes of "AAAA\n" and "BBBB\n" -> the output is "AAAA\n" fully, one idle cycle, then "BBBB\n"; no mixing.
- Round-robin: all 4 requesters commit "x\n" in the same cycle with rr_ptr=0 -> drain order 0,1,2,3; a second simultaneous round gives order 0,1,2,3 again (rr_ptr wraps to 0).
- Full buffer (LINE_BYTES=4): req2 sends 6 bytes 0x31..0x36 with no newline -> 0x31..0x34 are emitted, req_ready[2]=0 during the stall, then 0x35,0x36 are buffered and held pending flush/newline.
- Timeout (FLUSH_CYCLES=8): req1 sends 0x41 then idles -> commit after 8 idle cycles, then a single putchar of 0x41.
- Reset mid-drain: assert reset=0 during the 2nd byte of a 5-byte line -> putchar_valid=0 from the next edge, busy=0, and no remaining bytes are emitted after release.
